// File: rtl/l3_instr_issue.sv
// Instruction sequencer feeding the l3 control state machine: program memory, PC,
// execute handshake against the machine's cur_state, step mode, HALT opcode and watchdog.
//
// state     | meaning
// ----------+---------------------------------------------------------------
// STOP      | idle after reset, program memory writable
// FETCH     | registered read of the word at pc
// DECODE    | HALT check, otherwise present operation/data and raise execute
// WAIT_DONE | execute held until the control machine reports DONE
// RELEASE   | execute low, waiting for the control machine to return to IDLE
// ADVANCE   | increment pc, then run on or pause
// PAUSE     | single-step hold, waiting for a step pulse
// HALT      | HALT opcode reached, pc frozen, program memory writable
// ERR       | watchdog trap, pc frozen, program memory writable
module l3_instr_issue #(
  parameter int DATA_W  = 8,
  parameter int ADDR_W  = 4,
  parameter int TIMEOUT = 15
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic              step_mode,
  input  logic              step,
  input  logic              prog_we,
  input  logic [ADDR_W-1:0] prog_addr,
  input  logic [DATA_W+2:0] prog_wdata,
  input  logic [3:0]        cur_state,
  output logic              execute,
  output logic [2:0]        operation,
  output logic [DATA_W-1:0] imm_data,
  output logic [ADDR_W-1:0] pc,
  output logic              busy,
  output logic              halted,
  output logic              error
);

  localparam int IW   = 3 + DATA_W;
  localparam int WD_W = $clog2(TIMEOUT + 1);
  localparam logic [2:0]      OP_HALT = 3'b101;
  localparam logic [3:0]      CS_IDLE = 4'b0000;
  localparam logic [3:0]      CS_DONE = 4'b1000;
  localparam logic [WD_W-1:0] WD_LOAD = WD_W'(TIMEOUT - 1);

  typedef enum logic [3:0] {
    S_STOP, S_FETCH, S_DECODE, S_WAIT_DONE, S_RELEASE,
    S_ADVANCE, S_PAUSE, S_HALT, S_ERR
  } state_t;

  state_t            state, state_nx;
  logic [IW-1:0]     mem [2**ADDR_W];
  logic [IW-1:0]     instr;
  logic [WD_W-1:0]   wd, wd_nx;
  logic [ADDR_W-1:0] pc_nx;
  logic [2:0]        operation_nx;
  logic [DATA_W-1:0] imm_data_nx;
  logic              execute_nx, halted_nx, error_nx, busy_nx;
  logic              prog_en;

  assign prog_en = (state == S_STOP) || (state == S_HALT) || (state == S_ERR);

  always_ff @(posedge clk) begin
    if (rst_n && prog_we && prog_en)
      mem[prog_addr] <= prog_wdata;
    if (state == S_FETCH)
      instr <= mem[pc];
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state     <= S_STOP;
      pc        <= '0;
      execute   <= 1'b0;
      operation <= '0;
      imm_data  <= '0;
      busy      <= 1'b0;
      halted    <= 1'b0;
      error     <= 1'b0;
      wd        <= '0;
    end else begin
      state     <= state_nx;
      pc        <= pc_nx;
      execute   <= execute_nx;
      operation <= operation_nx;
      imm_data  <= imm_data_nx;
      busy      <= busy_nx;
      halted    <= halted_nx;
      error     <= error_nx;
      wd        <= wd_nx;
    end
  end

  // The watchdog counts down from TIMEOUT-1; reaching zero without progress traps.
  always_comb begin
    state_nx     = state;
    pc_nx        = pc;
    execute_nx   = execute;
    operation_nx = operation;
    imm_data_nx  = imm_data;
    halted_nx    = halted;
    error_nx     = error;
    wd_nx        = wd;
    unique case (state)
      S_STOP: begin
        if (start) begin
          pc_nx    = '0;
          state_nx = S_FETCH;
        end
      end
      S_FETCH: state_nx = S_DECODE;
      S_DECODE: begin
        if (instr[IW-1 -: 3] == OP_HALT) begin
          halted_nx = 1'b1;
          state_nx  = S_HALT;
        end else begin
          operation_nx = instr[IW-1 -: 3];
          imm_data_nx  = instr[DATA_W-1:0];
          execute_nx   = 1'b1;
          wd_nx        = WD_LOAD;
          state_nx     = S_WAIT_DONE;
        end
      end
      S_WAIT_DONE: begin
        if (cur_state == CS_DONE) begin
          execute_nx = 1'b0;
          wd_nx      = WD_LOAD;
          state_nx   = S_RELEASE;
        end else if (wd == '0) begin
          execute_nx = 1'b0;
          error_nx   = 1'b1;
          state_nx   = S_ERR;
        end else begin
          wd_nx = wd - 1'b1;
        end
      end
      S_RELEASE: begin
        if (cur_state == CS_IDLE) begin
          state_nx = S_ADVANCE;
        end else if (wd == '0) begin
          error_nx = 1'b1;
          state_nx = S_ERR;
        end else begin
          wd_nx = wd - 1'b1;
        end
      end
      S_ADVANCE: begin
        pc_nx    = pc + 1'b1;
        state_nx = step_mode ? S_PAUSE : S_FETCH;
      end
      S_PAUSE: begin
        if (step)
          state_nx = S_FETCH;
      end
      S_HALT, S_ERR: begin
        if (start) begin
          halted_nx = 1'b0;
          error_nx  = 1'b0;
          pc_nx     = '0;
          state_nx  = S_FETCH;
        end
      end
      default: state_nx = S_STOP;
    endcase
    busy_nx = !((state_nx == S_STOP) || (state_nx == S_HALT) || (state_nx == S_ERR));
  end

endmodule

// File: tb/tb_l3_instr_issue.sv
// Directed bench for l3_instr_issue with a small behavioural control-machine responder.
module tb_l3_instr_issue;

  localparam int DATA_W  = 8;
  localparam int ADDR_W  = 4;
  localparam int TIMEOUT = 15;

  logic              clk = 1'b0;
  logic              rst_n, start, step_mode, step, prog_we;
  logic [ADDR_W-1:0] prog_addr;
  logic [DATA_W+2:0] prog_wdata;
  logic [3:0]        cur_state = 4'b0000;
  logic              execute, busy, halted, error;
  logic [2:0]        operation;
  logic [DATA_W-1:0] imm_data;
  logic [ADDR_W-1:0] pc;

  logic              hang = 1'b0;
  int                dly = 2;
  int                mcnt = 0;
  int                n_chk = 0;
  int                n_err = 0;
  int                cnt;

  l3_instr_issue #(.DATA_W(DATA_W), .ADDR_W(ADDR_W), .TIMEOUT(TIMEOUT)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .step_mode(step_mode), .step(step),
    .prog_we(prog_we), .prog_addr(prog_addr), .prog_wdata(prog_wdata),
    .cur_state(cur_state), .execute(execute), .operation(operation),
    .imm_data(imm_data), .pc(pc), .busy(busy), .halted(halted), .error(error)
  );

  always #5 clk = ~clk;

  // Control machine stand-in: IDLE -> RUN (dly cycles) -> DONE, back to IDLE once execute drops.
  always @(posedge clk) begin
    case (cur_state)
      4'b0000: if (execute && !hang) begin cur_state <= 4'b0001; mcnt <= dly; end
      4'b0001: begin
        if (!execute) cur_state <= 4'b0000;
        else if (mcnt == 0) cur_state <= 4'b1000;
        else mcnt <= mcnt - 1;
      end
      4'b1000: if (!execute) cur_state <= 4'b0000;
      default: cur_state <= 4'b0000;
    endcase
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic cyc();
    @(negedge clk);
  endtask

  task automatic write_word(input int a, input logic [2:0] op, input logic [7:0] d);
    prog_we = 1'b1; prog_addr = ADDR_W'(a); prog_wdata = {op, d};
    cyc();
    prog_we = 1'b0;
  endtask

  task automatic pulse_start();
    start = 1'b1; cyc(); start = 1'b0;
  endtask

  task automatic pulse_step();
    step = 1'b1; cyc(); step = 1'b0;
  endtask

  task automatic wait_exec(input logic v, input string tag);
    for (int i = 0; i < 200 && execute !== v; i++) cyc();
    check(tag, 32'(execute), 32'(v));
  endtask

  task automatic wait_done_fall(input string tag);
    for (int i = 0; i < 200 && cur_state != 4'b1000; i++) cyc();
    check({tag, "_exec_at_done"}, 32'(execute), 1);
    cyc();
    check({tag, "_exec_fall"}, 32'(execute), 0);
  endtask

  initial begin
    rst_n = 1'b0; start = 1'b0; step_mode = 1'b0; step = 1'b0;
    prog_we = 1'b0; prog_addr = '0; prog_wdata = '0;
    cyc(); cyc();
    check("rst_execute", 32'(execute), 0);
    check("rst_operation", 32'(operation), 0);
    check("rst_imm", 32'(imm_data), 0);
    check("rst_pc", 32'(pc), 0);
    check("rst_busy", 32'(busy), 0);
    check("rst_halted", 32'(halted), 0);
    check("rst_error", 32'(error), 0);
    rst_n = 1'b1;
    cyc();

    // Run to completion
    write_word(0, 3'b000, 8'h05);
    write_word(1, 3'b111, 8'h03);
    write_word(2, 3'b101, 8'h00);
    pulse_start();
    check("run_busy", 32'(busy), 1);
    check("run_exec_k", 32'(execute), 0);
    cyc();
    check("run_exec_k1", 32'(execute), 0);
    cyc();
    check("run_exec_k2", 32'(execute), 1);
    check("run_op0", 32'(operation), 0);
    check("run_imm0", 32'(imm_data), 32'h05);
    check("run_pc0", 32'(pc), 0);
    wait_done_fall("run_i0");
    wait_exec(1'b1, "run_exec_i1");
    check("run_op1", 32'(operation), 32'b111);
    check("run_imm1", 32'(imm_data), 32'h03);
    check("run_pc1", 32'(pc), 1);
    wait_done_fall("run_i1");
    for (int i = 0; i < 200 && !halted; i++) cyc();
    check("run_halted", 32'(halted), 1);
    check("run_busy_end", 32'(busy), 0);
    check("run_pc_end", 32'(pc), 2);
    check("run_exec_end", 32'(execute), 0);
    check("run_op_retain", 32'(operation), 32'b111);

    // Watchdog trap
    write_word(0, 3'b011, 8'h00);
    hang = 1'b1;
    pulse_start();
    check("wd_halted_clr", 32'(halted), 0);
    cyc(); cyc();
    cnt = 0;
    for (int i = 0; i < 100 && execute; i++) begin cnt++; cyc(); end
    check("wd_exec_cycles", 32'(cnt), TIMEOUT);
    check("wd_error", 32'(error), 1);
    check("wd_exec", 32'(execute), 0);
    check("wd_busy", 32'(busy), 0);
    check("wd_pc", 32'(pc), 0);
    check("wd_halted", 32'(halted), 0);
    repeat (3) cyc();
    check("wd_pc_frozen", 32'(pc), 0);
    hang = 1'b0;
    pulse_start();
    check("wd_error_clr", 32'(error), 0);
    check("wd_busy_restart", 32'(busy), 1);
    cyc(); cyc();
    check("wd_refetch_exec", 32'(execute), 1);
    check("wd_refetch_op", 32'(operation), 32'b011);
    // write while busy must be ignored
    write_word(1, 3'b000, 8'hAA);
    wait_exec(1'b0, "wd_exec_rel");
    wait_exec(1'b1, "wd_exec_i1");
    check("busy_write_op", 32'(operation), 32'b111);
    check("busy_write_imm", 32'(imm_data), 32'h03);
    for (int i = 0; i < 200 && !halted; i++) cyc();
    check("wd_run_halted", 32'(halted), 1);

    // Single-step
    write_word(0, 3'b000, 8'h11);
    write_word(1, 3'b001, 8'h22);
    step_mode = 1'b1;
    pulse_start();
    for (int i = 0; i < 200 && pc != 1; i++) cyc();
    check("ss_pc1", 32'(pc), 1);
    check("ss_busy1", 32'(busy), 1);
    check("ss_exec1", 32'(execute), 0);
    check("ss_imm_retain", 32'(imm_data), 32'h11);
    repeat (5) cyc();
    check("ss_pc_hold", 32'(pc), 1);
    check("ss_no_fetch", 32'(execute), 0);
    pulse_step();
    wait_exec(1'b1, "ss_exec_i1");
    check("ss_op1", 32'(operation), 32'b001);
    check("ss_imm1", 32'(imm_data), 32'h22);
    for (int i = 0; i < 200 && pc != 2; i++) cyc();
    check("ss_pc2", 32'(pc), 2);
    check("ss_busy2", 32'(busy), 1);
    check("ss_exec2", 32'(execute), 0);
    pulse_step();
    for (int i = 0; i < 50 && !halted; i++) cyc();
    check("ss_halted", 32'(halted), 1);
    check("ss_pc_end", 32'(pc), 2);
    check("ss_busy_end", 32'(busy), 0);

    // Wrap-around
    step_mode = 1'b0;
    for (int n = 0; n < 16; n++) write_word(n, 3'b100, 8'(n));
    pulse_start();
    for (int n = 0; n < 17; n++) begin
      wait_exec(1'b1, $sformatf("wrap_exec_%0d", n));
      check($sformatf("wrap_pc_%0d", n), 32'(pc), 32'(n % 16));
      check($sformatf("wrap_op_%0d", n), 32'(operation), 32'b100);
      check($sformatf("wrap_imm_%0d", n), 32'(imm_data), 32'(n % 16));
      wait_exec(1'b0, $sformatf("wrap_rel_%0d", n));
    end
    check("wrap_no_halt", 32'(halted), 0);
    check("wrap_busy", 32'(busy), 1);

    // Reset, then simultaneous write+start, then reset mid-add
    rst_n = 1'b0; cyc(); rst_n = 1'b1;
    check("rst2_busy", 32'(busy), 0);
    check("rst2_pc", 32'(pc), 0);
    cyc();
    dly = 10;
    prog_we = 1'b1; prog_addr = '0; prog_wdata = {3'b011, 8'h07}; start = 1'b1;
    cyc();
    prog_we = 1'b0; start = 1'b0;
    cyc(); cyc();
    check("we_start_exec", 32'(execute), 1);
    check("we_start_op", 32'(operation), 32'b011);
    check("we_start_imm", 32'(imm_data), 32'h07);
    repeat (3) cyc();
    check("midrst_pre_exec", 32'(execute), 1);
    rst_n = 1'b0;
    cyc();
    check("midrst_exec", 32'(execute), 0);
    check("midrst_pc", 32'(pc), 0);
    check("midrst_busy", 32'(busy), 0);
    check("midrst_op", 32'(operation), 0);
    rst_n = 1'b1;
    cyc();
    check("midrst_cs_idle", 32'(cur_state), 0);
    check("midrst_stay_stop", 32'(busy), 0);

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
